mem_wb_pipe_reg: RTL and testbench

//   Parametrised MEM->WB pipeline register; successor to the fixed-width flop-only stage.

---
 rtl/mem_wb_pipe_reg_if.sv | 24 ++
 rtl/mem_wb_pipe_reg.sv | 116 +++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_reg_if.sv
// Beat channel between pipeline stages: one valid/ready handshake carrying
// the register-file write-back fields of a single instruction.
interface mem_wb_pipe_reg_if #(
  parameter int RWIDTH = 5,
  parameter int WORD   = 32
);
  logic              valid;
  logic              ready;
  logic              reg_write;
  logic              mem_to_reg;
  logic [RWIDTH-1:0] mux8_out;
  logic [WORD-1:0]   read_data;
  logic [WORD-1:0]   alu_result;

  modport master (
    output valid, reg_write, mem_to_reg, mux8_out, read_data, alu_result,
    input  ready
  );

  modport slave (
    input  valid, reg_write, mem_to_reg, mux8_out, read_data, alu_result,
    output ready
  );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with a two-entry skid buffer, synchronous flush,
// $0 write suppression, write-back data select and a saturating stall counter.
module mem_wb_pipe_reg #(
  parameter int RWIDTH = 5,
  parameter int WORD   = 32,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  mem_wb_pipe_reg_if.slave  mem,
  mem_wb_pipe_reg_if.master wb,
  output logic [WORD-1:0] write_data,
  output logic            write_en,
  output logic [CNTW-1:0] stall_count
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [RWIDTH-1:0] mux8_out;
    logic [WORD-1:0]   read_data;
    logic [WORD-1:0]   alu_result;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  beat_t           head;
  beat_t           skid;
  beat_t           incoming;
  logic            ready_q;
  logic [CNTW-1:0] stall_q;
  logic            acc;
  logic            pop;

  // Writes to $0 are discarded at capture so WB never needs to re-check the index.
  always_comb begin
    incoming            = '0;
    incoming.reg_write  = mem.reg_write & (mem.mux8_out != '0);
    incoming.mem_to_reg = mem.mem_to_reg;
    incoming.mux8_out   = mem.mux8_out;
    incoming.read_data  = mem.read_data;
    incoming.alu_result = mem.alu_result;
  end

  assign acc = mem.valid & ready_q;
  assign pop = wb.valid & wb.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b1;
      stall_q <= '0;
    end else begin
      if (wb.valid && !wb.ready && stall_q != {CNTW{1'b1}})
        stall_q <= stall_q + CNTW'(1);

      if (flush) begin
        state   <= EMPTY;
        ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              head  <= incoming;
              state <= ONE;
            end
          end
          ONE: begin
            if (acc && pop) begin
              head <= incoming;
            end else if (acc) begin
              skid    <= incoming;
              state   <= FULL;
              ready_q <= 1'b0;
            end else if (pop) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            // Ready stays low here, so the skid entry is the only possible refill.
            if (pop) begin
              head    <= skid;
              state   <= ONE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state   <= EMPTY;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign mem.ready     = ready_q;
  assign wb.valid      = (state != EMPTY);
  assign wb.reg_write  = head.reg_write;
  assign wb.mem_to_reg = head.mem_to_reg;
  assign wb.mux8_out   = head.mux8_out;
  assign wb.read_data  = head.read_data;
  assign wb.alu_result = head.alu_result;

  assign write_data  = head.mem_to_reg ? head.read_data : head.alu_result;
  assign write_en    = wb.valid & wb.ready & head.reg_write;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg: directed scenarios plus a random
// run compared against a queue-based model of the stage.
module tb_mem_wb_pipe_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  mem_wb_pipe_reg_if #(.RWIDTH(5), .WORD(32)) mem_if ();
  mem_wb_pipe_reg_if #(.RWIDTH(5), .WORD(32)) wb_if ();
  logic [31:0] write_data;
  logic        write_en;
  logic [15:0] stall_count;

  mem_wb_pipe_reg #(.RWIDTH(5), .WORD(32), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mem(mem_if.slave), .wb(wb_if.master),
    .write_data(write_data), .write_en(write_en), .stall_count(stall_count)
  );

  // Narrow-counter instance used only to observe saturation.
  mem_wb_pipe_reg_if #(.RWIDTH(5), .WORD(32)) s_mem_if ();
  mem_wb_pipe_reg_if #(.RWIDTH(5), .WORD(32)) s_wb_if ();
  logic [31:0] s_write_data;
  logic        s_write_en;
  logic [3:0]  s_stall_count;
  logic        s_flush = 1'b0;

  mem_wb_pipe_reg #(.RWIDTH(5), .WORD(32), .CNTW(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .mem(s_mem_if.slave), .wb(s_wb_if.master),
    .write_data(s_write_data), .write_en(s_write_en), .stall_count(s_stall_count)
  );

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] alu;
  } tb_beat_t;

  tb_beat_t mq[$];
  bit       model_ready;
  int       model_stall;
  int       errors = 0;
  int       checks = 0;

  task automatic set_beat(input logic v, input logic rw, input logic m2r,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] alu);
    mem_if.valid      = v;
    mem_if.reg_write  = rw;
    mem_if.mem_to_reg = m2r;
    mem_if.mux8_out   = rd;
    mem_if.read_data  = rdata;
    mem_if.alu_result = alu;
  endtask

  // Model: a FIFO of at most two beats, refilled after the head leaves.
  task automatic model_step();
    tb_beat_t b;
    bit acc;
    bit pop;
    acc = mem_if.valid && model_ready;
    pop = (mq.size() > 0) && wb_if.ready;
    if (mq.size() > 0 && !wb_if.ready && model_stall < 65535) model_stall++;
    if (pop) void'(mq.pop_front());
    if (flush) begin
      mq.delete();
    end else if (acc) begin
      b.rw    = mem_if.reg_write && (mem_if.mux8_out != 5'd0);
      b.m2r   = mem_if.mem_to_reg;
      b.rd    = mem_if.mux8_out;
      b.rdata = mem_if.read_data;
      b.alu   = mem_if.alu_result;
      mq.push_back(b);
    end
    model_ready = (mq.size() < 2);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0;
    set_beat(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    wb_if.ready = 1'b0;
    s_mem_if.valid = 1'b0; s_mem_if.reg_write = 1'b0; s_mem_if.mem_to_reg = 1'b0;
    s_mem_if.mux8_out = 5'd0; s_mem_if.read_data = 32'd0; s_mem_if.alu_result = 32'd0;
    s_wb_if.ready = 1'b0;
    mq.delete();
    model_ready = 1'b1;
    model_stall = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", wb_if.valid); end
    checks++; if (mem_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", mem_if.ready); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall got=%0d exp=0", stall_count); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got=%b exp=0", write_en); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdata got=%h exp=0", write_data); end
    checks++; if (wb_if.mux8_out !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd got=%0d exp=0", wb_if.mux8_out); end
    checks++; if (wb_if.reg_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_rw got=%b exp=0", wb_if.reg_write); end
    do_reset();
  endtask

  task automatic test_first_beat();
    do_reset();
    set_beat(1'b1, 1'b1, 1'b0, 5'd5, 32'h0, 32'h1234);
    wb_if.ready = 1'b1;
    tick();
    checks++; if (wb_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL first_valid got=%b exp=1", wb_if.valid); end
    checks++; if (write_data !== 32'h1234) begin errors++; $display("[TB] FAIL first_wdata got=%h exp=1234", write_data); end
    checks++; if (write_en !== 1'b1) begin errors++; $display("[TB] FAIL first_wen got=%b exp=1", write_en); end
    checks++; if (wb_if.mux8_out !== 5'd5) begin errors++; $display("[TB] FAIL first_rd got=%0d exp=5", wb_if.mux8_out); end
    set_beat(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL first_drain got=%b exp=0", wb_if.valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wb_if.ready = 1'b0;
    set_beat(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 32'hA);
    tick();
    checks++; if (wb_if.alu_result !== 32'hA || wb_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_headA got=%h/%b exp=a/1", wb_if.alu_result, wb_if.valid); end
    checks++; if (mem_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_one got=%b exp=1", mem_if.ready); end
    set_beat(1'b1, 1'b1, 1'b0, 5'd2, 32'd0, 32'hB);
    tick();
    checks++; if (mem_if.ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_full got=%b exp=0", mem_if.ready); end
    set_beat(1'b1, 1'b1, 1'b0, 5'd3, 32'd0, 32'hC);
    repeat (3) tick();
    checks++; if (wb_if.alu_result !== 32'hA) begin errors++; $display("[TB] FAIL b2b_hold got=%h exp=a", wb_if.alu_result); end
    checks++; if (stall_count !== 16'd4) begin errors++; $display("[TB] FAIL b2b_stall got=%0d exp=4", stall_count); end
    wb_if.ready = 1'b1;
    tick();
    checks++; if (wb_if.alu_result !== 32'hB || wb_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_headB got=%h/%b exp=b/1", wb_if.alu_result, wb_if.valid); end
    tick();
    checks++; if (wb_if.alu_result !== 32'hC || wb_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_headC got=%h/%b exp=c/1", wb_if.alu_result, wb_if.valid); end
    set_beat(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty got=%b exp=0", wb_if.valid); end
    checks++; if (stall_count !== 16'd4) begin errors++; $display("[TB] FAIL b2b_stall_end got=%0d exp=4", stall_count); end
  endtask

  task automatic test_memtoreg();
    do_reset();
    wb_if.ready = 1'b0;
    set_beat(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 32'h1);
    tick();
    set_beat(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL m2r_wdata got=%h exp=deadbeef", write_data); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("[TB] FAIL m2r_wen_stalled got=%b exp=0", write_en); end
    wb_if.ready = 1'b1;
    #1;
    checks++; if (write_en !== 1'b1) begin errors++; $display("[TB] FAIL m2r_wen got=%b exp=1", write_en); end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    wb_if.ready = 1'b1;
    set_beat(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'h55);
    tick();
    set_beat(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    checks++; if (wb_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid got=%b exp=1", wb_if.valid); end
    checks++; if (wb_if.reg_write !== 1'b0) begin errors++; $display("[TB] FAIL zero_rw got=%b exp=0", wb_if.reg_write); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("[TB] FAIL zero_wen got=%b exp=0", write_en); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    wb_if.ready = 1'b0;
    set_beat(1'b1, 1'b1, 1'b0, 5'd4, 32'd0, 32'hA1);
    tick();
    set_beat(1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 32'hB2);
    tick();
    set_beat(1'b1, 1'b1, 1'b0, 5'd6, 32'd0, 32'hD4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got=%b exp=0", wb_if.valid); end
    checks++; if (mem_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got=%b exp=1", mem_if.ready); end
    checks++; if (stall_count !== 16'd2) begin errors++; $display("[TB] FAIL flush_stall got=%0d exp=2", stall_count); end
    set_beat(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    wb_if.ready = 1'b1;
    tick();
    checks++; if (wb_if.valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_ghost got=%b exp=0", wb_if.valid); end
    set_beat(1'b1, 1'b1, 1'b0, 5'd7, 32'd0, 32'hE5);
    tick();
    set_beat(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    checks++; if (wb_if.valid !== 1'b1 || wb_if.alu_result !== 32'hE5) begin errors++; $display("[TB] FAIL flush_next got=%b/%h exp=1/e5", wb_if.valid, wb_if.alu_result); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      checks++; if (wb_if.valid !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", i, wb_if.valid, mq.size() > 0); end
      checks++; if (mem_if.ready !== model_ready) begin errors++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", i, mem_if.ready, model_ready); end
      checks++; if (stall_count !== 16'(model_stall)) begin errors++; $display("[TB] FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, stall_count, model_stall); end
      if (mq.size() > 0) begin
        checks++;
        if (wb_if.alu_result !== mq[0].alu || wb_if.read_data !== mq[0].rdata ||
            wb_if.mux8_out !== mq[0].rd || wb_if.reg_write !== mq[0].rw || wb_if.mem_to_reg !== mq[0].m2r) begin
          errors++;
          $display("[TB] FAIL rnd_head cyc=%0d got=%h/%h/%0d/%b/%b exp=%h/%h/%0d/%b/%b", i,
                   wb_if.alu_result, wb_if.read_data, wb_if.mux8_out, wb_if.reg_write, wb_if.mem_to_reg,
                   mq[0].alu, mq[0].rdata, mq[0].rd, mq[0].rw, mq[0].m2r);
        end
      end
      set_beat($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)),
               $urandom, $urandom);
      wb_if.ready = $urandom_range(0, 9) < 6;
      flush = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (write_en !== ((mq.size() > 0) && wb_if.ready && mq[0].rw)) begin errors++; $display("[TB] FAIL rnd_wen cyc=%0d got=%b", i, write_en); end
      if (mq.size() > 0) begin
        checks++; if (write_data !== (mq[0].m2r ? mq[0].rdata : mq[0].alu)) begin errors++; $display("[TB] FAIL rnd_wdata cyc=%0d got=%h", i, write_data); end
      end
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    s_wb_if.ready = 1'b0;
    s_mem_if.valid = 1'b1; s_mem_if.reg_write = 1'b1; s_mem_if.mux8_out = 5'd7;
    s_mem_if.alu_result = 32'h77;
    tick();
    s_mem_if.valid = 1'b0;
    repeat (20) tick();
    checks++; if (s_stall_count !== 4'd15) begin errors++; $display("[TB] FAIL sat_count got=%0d exp=15", s_stall_count); end
    checks++; if (s_wb_if.valid !== 1'b1) begin errors++; $display("[TB] FAIL sat_valid got=%b exp=1", s_wb_if.valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (s_stall_count !== 4'd0) begin errors++; $display("[TB] FAIL sat_async_clear got=%0d exp=0", s_stall_count); end
    checks++; if (s_wb_if.valid !== 1'b0 || s_mem_if.ready !== 1'b1) begin errors++; $display("[TB] FAIL sat_async_out got=%b/%b exp=0/1", s_wb_if.valid, s_mem_if.ready); end
  endtask

  initial begin
    set_beat(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    wb_if.ready = 1'b0;
    s_mem_if.valid = 1'b0; s_mem_if.reg_write = 1'b0; s_mem_if.mem_to_reg = 1'b0;
    s_mem_if.mux8_out = 5'd0; s_mem_if.read_data = 32'd0; s_mem_if.alu_result = 32'd0;
    s_wb_if.ready = 1'b0;
    model_ready = 1'b1;
    model_stall = 0;
    test_reset();
    test_first_beat();
    test_back_to_back();
    test_memtoreg();
    test_zero_reg();
    test_flush();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
